// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-add MUL/MLA sequencer for the E stage; stalls F/D/E while it iterates.
// Optional early termination on a zero multiplier is enabled by defining MUL_EARLY_TERM_EN.
module mul_seq_ctrl #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MulStartE,
    input  logic             MulAccE,
    input  logic             MulKillE,
    input  logic [WIDTH-1:0] RmE,
    input  logic [WIDTH-1:0] RsE,
    input  logic [WIDTH-1:0] RaE,
    output logic             StallMul,
    output logic             MulBusy,
    output logic             MulDoneE,
    output logic [WIDTH-1:0] MulResultE,
    output logic [1:0]       MulFlagsE
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] partial, acc_sum, mplier_shift, start_acc;
    logic             start_ok, rs_zero, next_zero;

    // One digit of the multiplier times the shifted multiplicand, built from shifted adds.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    assign acc_sum      = acc + partial;
    assign mplier_shift = mplier >> BITS_PER_CYCLE;
    assign start_acc    = MulAccE ? RaE : '0;
    assign start_ok     = MulStartE & ~MulKillE;

`ifdef MUL_EARLY_TERM_EN
    assign rs_zero   = (RsE == '0);
    assign next_zero = (mplier_shift == '0);
`else
    assign rs_zero   = 1'b0;
    assign next_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        StallMul   = 1'b0;
        MulBusy    = 1'b0;
        MulDoneE   = 1'b0;
        MulResultE = '0;
        MulFlagsE  = 2'b00;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    StallMul   = 1'b1;
                    state_next = rs_zero ? DONE : RUN;
                end
            end
            RUN: begin
                MulBusy = 1'b1;
                if (MulKillE) begin
                    state_next = IDLE;
                end else begin
                    StallMul = 1'b1;
                    if (cnt == CNT_W'(1) || next_zero) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // Start is still high for the same instruction here; it must not re-launch.
                MulDoneE   = 1'b1;
                MulResultE = acc;
                MulFlagsE  = {acc[WIDTH-1], (acc == '0)};
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        mcand  <= RmE;
                        mplier <= RsE;
                        acc    <= start_acc;
                        cnt    <= CNT_W'(STEPS);
                    end
                end
                RUN: begin
                    if (!MulKillE) begin
                        acc    <= acc_sum;
                        mcand  <= mcand << BITS_PER_CYCLE;
                        mplier <= mplier_shift;
                        cnt    <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: stimulus pushes expected products/latencies, a monitor checks DONE strobes.
module tb_mul_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int BPC   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             MulStartE, MulAccE, MulKillE;
    logic [WIDTH-1:0] RmE, RsE, RaE;
    logic             StallMul, MulBusy, MulDoneE;
    logic [WIDTH-1:0] MulResultE;
    logic [1:0]       MulFlagsE;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [1:0]       flags;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    mul_seq_ctrl #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (
        .clk        (clk),
        .reset      (reset),
        .MulStartE  (MulStartE),
        .MulAccE    (MulAccE),
        .MulKillE   (MulKillE),
        .RmE        (RmE),
        .RsE        (RsE),
        .RaE        (RaE),
        .StallMul   (StallMul),
        .MulBusy    (MulBusy),
        .MulDoneE   (MulDoneE),
        .MulResultE (MulResultE),
        .MulFlagsE  (MulFlagsE)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Latency from start cycle to DONE cycle, derived from the multiplier's bit length.
    function automatic int refLatency(input logic [WIDTH-1:0] rs);
`ifdef MUL_EARLY_TERM_EN
        int bl = 0;
        if (rs == '0) return 1;
        for (int i = 0; i < WIDTH; i++) if (rs[i]) bl = i + 1;
        return (bl + BPC - 1) / BPC + 1;
`else
        return WIDTH / BPC + 1;
`endif
    endfunction

    // Issues one multiply, holds start like a stalled pipeline, returns in the DONE cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] rm, input logic [WIDTH-1:0] rs,
                                 input logic [WIDTH-1:0] ra, input logic isAcc);
        exp_t          e;
        logic [63:0]   full;
        bit            done = 0;
        @(negedge clk);
        MulStartE = 1'b1;
        MulKillE  = 1'b0;
        MulAccE   = isAcc;
        RmE       = rm;
        RsE       = rs;
        RaE       = ra;
        full      = 64'(rm) * 64'(rs) + (isAcc ? 64'(ra) : 64'd0);
        e.res     = full[WIDTH-1:0];
        e.flags   = {e.res[WIDTH-1], (e.res == '0)};
        e.cyc     = cyc + refLatency(rs);
        sb.push_back(e);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!StallMul) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL stall_timeout: StallMul still 1, want release within 200 cycles");
        end
    endtask

    task automatic goIdle(input int n);
        @(negedge clk);
        MulStartE = 1'b0;
        MulKillE  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stall"}, 64'(StallMul), 64'd0);
        checkOutput({tag, "_busy"}, 64'(MulBusy), 64'd0);
        checkOutput({tag, "_done"}, 64'(MulDoneE), 64'd0);
        checkOutput({tag, "_result"}, 64'(MulResultE), 64'd0);
        checkOutput({tag, "_flags"}, 64'(MulFlagsE), 64'd0);
    endtask

    // Monitor: every DONE strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && MulDoneE) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL spurious_done: got result 0x%0h, want no strobe", MulResultE);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result", 64'(MulResultE), 64'(e.res));
                checkOutput("flags", 64'(MulFlagsE), 64'(e.flags));
                checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
                checkOutput("stall_in_done", 64'(StallMul), 64'd0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        MulStartE = 1'b0;
        MulAccE   = 1'b0;
        MulKillE  = 1'b0;
        RmE       = '0;
        RsE       = '0;
        RaE       = '0;
        repeat (3) @(negedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        applyStimulus(32'd3, 32'd5, 32'd0, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1);
        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
        applyStimulus(32'd3, 32'd4, 32'd0, 1'b0);
        applyStimulus(32'd5, 32'd5, 32'd0, 1'b0);
        applyStimulus(32'd11, 32'd3, 32'd0, 1'b0);
        applyStimulus(32'd5, 32'd0, 32'd9, 1'b1);
        goIdle(2);

        // Kill in the fifth RUN cycle, then an immediate fresh multiply.
        @(negedge clk);
        MulStartE = 1'b1;
        MulAccE   = 1'b0;
        RmE       = 32'h1234_5678;
        RsE       = 32'hFFFF_FFFF;
        repeat (5) @(negedge clk);
        MulKillE = 1'b1;
        #1;
        checkOutput("kill_stall", 64'(StallMul), 64'd0);
        @(negedge clk);
        MulStartE = 1'b0;
        MulKillE  = 1'b0;
        #1;
        checkOutput("post_kill_stall", 64'(StallMul), 64'd0);
        checkOutput("post_kill_busy", 64'(MulBusy), 64'd0);
        applyStimulus(32'd7, 32'd6, 32'd0, 1'b0);
        goIdle(1);

        // Reset in the eighth RUN cycle abandons the operation.
        @(negedge clk);
        MulStartE = 1'b1;
        RmE       = 32'hDEAD_BEEF;
        RsE       = 32'hF000_0001;
        repeat (8) @(negedge clk);
        reset     = 1'b1;
        MulStartE = 1'b0;
        @(negedge clk);
        #1;
        checkAllZero("mid_reset");
        reset = 1'b0;
        applyStimulus(32'd2, 32'd2, 32'd0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [WIDTH-1:0] rs;
            case ($urandom_range(0, 3))
                0:       rs = '0;
                1:       rs = WIDTH'($urandom_range(1, 255));
                default: rs = $urandom;
            endcase
            applyStimulus($urandom, rs, $urandom, 1'($urandom_range(0, 1)));
        end

        goIdle(40);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle multiply sequencer for the execute stage of the pipelined ARM core. Handles MUL and MLA.
- When a multiply reaches E, it stalls F/D/E, runs an iterative shift-add multiply over Rm, Rs and the optional accumulator Ra (the forwarded SrcAE/WriteDataE/SrcCE values), then releases the pipeline.
- On release, it presents the 32-bit product for one cycle, and that value enters the M-stage result register.
- The hazard unit ORs StallMul into StallF/StallD and the E-stage register enables.

Parameters:
- WIDTH, 32, operand and result width.
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration. Must divide WIDTH; legal values are 1, 2, 4.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous active-high reset
- MulStartE  input  1  valid multiply in E; held high by the pipeline while stalled
- MulAccE  input  1  1 = MLA (add Ra), 0 = MUL
- MulKillE  input  1  abort: condition failed or E flushed
- RmE  input  WIDTH  multiplicand (forwarded SrcAE)
- RsE  input  WIDTH  multiplier (forwarded WriteDataE)
- RaE  input  WIDTH  accumulator (forwarded SrcCE)
- StallMul  output  1  stall request to hazard unit
- MulBusy  output  1  high in RUN
- MulDoneE  output  1  one-cycle result-valid strobe
- MulResultE  output  WIDTH  product, valid when MulDoneE=1
- MulFlagsE  output  2  {N,Z} of MulResultE, valid when MulDoneE=1

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-high.
  - On reset: state=IDLE. StallMul, MulBusy, MulDoneE = 0. MulResultE = 0. MulFlagsE = 0. Internal registers cleared.
  - Reset mid-operation abandons the operation with no done strobe.
- States: IDLE, RUN, DONE.
- IDLE:
  - If MulStartE=1 and MulKillE=0, latch:
    - mcand <= RmE
    - mplier <= RsE
    - acc <= MulAccE ? RaE : 0
    - cnt <= WIDTH/BITS_PER_CYCLE
  - Then go to RUN.
  - StallMul = MulStartE & ~MulKillE, combinational in the same cycle, so the operands stay held.
  - If MulKillE=1, there is no start and no stall.
- RUN, each cycle:
  - acc <= acc + mcand * mplier[BITS_PER_CYCLE-1:0], modulo 2^WIDTH
  - mcand <<= BITS_PER_CYCLE
  - mplier >>= BITS_PER_CYCLE
  - cnt <= cnt - 1
  - StallMul=1, MulBusy=1.
  - When cnt==1, go to DONE.
  - MulKillE=1 in RUN: go to IDLE, StallMul drops that cycle, no MulDoneE.
  - MulStartE is ignored in RUN.
- DONE, exactly one cycle:
  - MulDoneE=1, MulResultE=acc.
  - MulFlagsE[1] = acc[WIDTH-1]; MulFlagsE[0] = (acc==0).
  - StallMul=0, so the instruction advances to M at the clock edge.
  - Next state is IDLE unconditionally.
  - MulStartE is still high in DONE (same instruction) and must NOT restart.
- Outputs outside DONE: MulResultE and MulFlagsE hold 0.
- Latency with the feature off:
  - start seen at cycle t, RUN for t+1..t+WIDTH/BITS_PER_CYCLE, DONE at t+WIDTH/BITS_PER_CYCLE+1.
  - StallMul is high for WIDTH/BITS_PER_CYCLE+1 cycles; 17 at the defaults.
- Back-to-back multiplies: the next multiply enters E the cycle after DONE, finds IDLE, and starts normally. There are no bubbles beyond the DONE cycle.
- Arithmetic: result = low WIDTH bits of Rm*Rs (+Ra). Signed and unsigned results are identical. Overflow wraps silently.
- Simultaneous events:
  - reset has priority over everything.
  - MulKillE has priority over MulStartE.
  - In DONE, MulKillE is ignored and the result stands.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- When defined:
  - In IDLE, a start with RsE==0 goes directly to DONE with result = MulAccE ? RaE : 0.
  - In RUN, go to DONE when cnt==1 or the next mplier value (after shift) ==0.
  - Latency = 1 + ceil(bitlen(Rs)/BITS_PER_CYCLE) + ... with DONE at t+k+1, where k = number of RUN cycles actually needed (k=0 for Rs=0).
  - StallMul tracks the state exactly as above.
- When undefined: fixed latency as specified, and the mplier==0 comparator is not synthesised.

Test Plan:
- MUL Rm=3, Rs=5, defaults, feature off -> StallMul high 17 cycles, MulDoneE at t+17, MulResultE=15, flags {0,0}.
- MLA Rm=0xFFFFFFFF, Rs=2, Ra=1 -> MulResultE=0xFFFFFFFF, flags {1,0}. MUL Rm=0x10000, Rs=0x10000 -> 0, flags {0,1}.
- Start, then MulKillE=1 in RUN cycle 5 -> IDLE next cycle, StallMul low, no MulDoneE. An immediately following MUL 7*6 -> 42.
- reset asserted in RUN cycle 8 -> all outputs 0 next cycle. A fresh MUL 2*2 after reset -> 4 at normal latency.
- Back-to-back MUL 3*4 then MUL 5*5 -> results 12 and 25 on DONE cycles 18 cycles apart. No spurious restart during the first DONE.
- MUL_EARLY_TERM_EN defined: Rs=3 -> DONE at t+2, result 3*Rm. Rs=0, MLA Ra=9 -> DONE at t+1, result 9.
